// File: rtl/imem_loader_if.sv
// Loader-side bundle: byte stream in, instruction-memory write port and core
// control out. The ADDR_W parameter must match the loader instance.
//
// Handshake: a byte moves on a rising clk edge where in_valid && in_ready.
// The producer keeps in_data stable while in_valid is high and the byte has
// not yet moved. in_ready is registered and does not depend on in_valid.
// imem_we is a single-cycle strobe; imem_addr/imem_wdata are only meaningful
// while it is high.
interface imem_loader_if #(
    parameter int ADDR_W = 8
) ();
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;
    // Loader FSM state for debug and checker binding
    // (IDLE=0 LEN0=1 LEN1=2 DATA=3 WRITE=4 DONE=5 ERR=6).
    logic [2:0]        state;

    // Stream source / controller side.
    modport master (
        output start, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata,
        input  core_rst, busy, done, error, word_count, state
    );

    // Loader side.
    modport slave (
        input  start, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata,
        output core_rst, busy, done, error, word_count, state
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader. Takes a 16-bit little-endian word
// count N followed by 4*N bytes, assembles little-endian 32-bit words, writes
// them to consecutive word addresses from 0, and keeps the core in reset
// until the whole image has been written.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    // All control outputs are pure functions of the state being entered,
    // registered alongside the state so they change on the same edge.
    typedef struct packed {
        logic in_ready;
        logic imem_we;
        logic busy;
        logic done;
        logic error;
        logic core_rst;
    } flags_t;

    function automatic flags_t moore(input state_t s);
        flags_t f;
        f.in_ready = (s == LEN0) || (s == LEN1) || (s == DATA);
        f.imem_we  = (s == WRITE);
        f.busy     = (s == LEN0) || (s == LEN1) || (s == DATA) || (s == WRITE);
        f.done     = (s == DONE);
        f.error    = (s == ERR);
        f.core_rst = (s != DONE);
        return f;
    endfunction

    state_t            state;
    flags_t            flags;
    logic [15:0]       len;        // header word count N
    logic [1:0]        idx;        // byte position within the current word
    logic [23:0]       word_buf;   // bytes 0..2 of the word; byte 3 arrives last
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [ADDR_W:0]   word_count;

    logic              xfer;
    logic [16:0]       hdr_n;
    logic              hdr_too_big;
    logic              hdr_zero;
    logic [16:0]       wc_inc;
    logic              last_word;

    assign xfer        = bus.in_valid && flags.in_ready;
    // Full header as seen while the high byte is on the bus.
    assign hdr_n       = {1'b0, bus.in_data, len[7:0]};
    assign hdr_too_big = hdr_n > 17'(DEPTH);
    assign hdr_zero    = (hdr_n == 17'd0);
    // Count after the word in WRITE is retired; decides DONE vs. more data.
    assign wc_inc      = 17'(word_count) + 17'd1;
    assign last_word   = (wc_inc == {1'b0, len});

    // Loader FSM with its datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            flags      <= moore(IDLE);
            len        <= '0;
            idx        <= '0;
            word_buf   <= '0;
            addr       <= '0;
            wdata      <= '0;
            word_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= LEN0;
                        flags      <= moore(LEN0);
                        word_count <= '0;
                    end
                end

                LEN0: begin
                    if (xfer) begin
                        len[7:0] <= bus.in_data;
                        state    <= LEN1;
                        flags    <= moore(LEN1);
                    end
                end

                LEN1: begin
                    if (xfer) begin
                        len[15:8] <= bus.in_data;
                        if (hdr_too_big) begin
                            state <= ERR;
                            flags <= moore(ERR);
                        end else if (hdr_zero) begin
                            state <= DONE;
                            flags <= moore(DONE);
                        end else begin
                            idx        <= '0;
                            word_count <= '0;
                            state      <= DATA;
                            flags      <= moore(DATA);
                        end
                    end
                end

                DATA: begin
                    if (xfer) begin
                        if (idx == 2'd3) begin
                            // Fourth byte completes the word; present it for one
                            // write cycle at the next sequential address.
                            wdata <= {bus.in_data, word_buf};
                            addr  <= word_count[ADDR_W-1:0];
                            idx   <= '0;
                            state <= WRITE;
                            flags <= moore(WRITE);
                        end else begin
                            case (idx)
                                2'd0:    word_buf[7:0]   <= bus.in_data;
                                2'd1:    word_buf[15:8]  <= bus.in_data;
                                default: word_buf[23:16] <= bus.in_data;
                            endcase
                            idx <= idx + 2'd1;
                        end
                    end
                end

                WRITE: begin
                    word_count <= word_count + 1'b1;
                    if (last_word) begin
                        state <= DONE;
                        flags <= moore(DONE);
                    end else begin
                        state <= DATA;
                        flags <= moore(DATA);
                    end
                end

                DONE, ERR: begin
                    // A new load restarts the core's reset and clears the
                    // previous result on the same edge.
                    if (bus.start) begin
                        word_count <= '0;
                        state      <= LEN0;
                        flags      <= moore(LEN0);
                    end
                end

                default: begin
                    state <= IDLE;
                    flags <= moore(IDLE);
                end
            endcase
        end
    end

    assign bus.in_ready   = flags.in_ready;
    assign bus.imem_we    = flags.imem_we;
    assign bus.busy       = flags.busy;
    assign bus.done       = flags.done;
    assign bus.error      = flags.error;
    assign bus.core_rst   = flags.core_rst;
    assign bus.imem_addr  = addr;
    assign bus.imem_wdata = wdata;
    assign bus.word_count = word_count;
    assign bus.state      = state;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of complete loads plus hand-written sequences
// for reset, start-while-busy, full-depth image and mid-load reset.
module tb_imem_loader;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cycle = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W+31:0] exp_w;
    int  t_first = 0;
    bit  first_pending = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every write strobe must match the next expected {addr, word}.
    always @(negedge clk) begin
        if (!rst && bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                exp_w = exp_q.pop_front();
                check("imem_write", {bus.imem_addr, bus.imem_wdata}, exp_w);
            end
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int g;
        int n;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (g) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: got in_ready=%0b expected 1 within 50 cycles", bus.in_ready);
            bus.in_valid = 1'b0;
            return;
        end
        if (first_pending) begin
            t_first       = cycle + 1;
            first_pending = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap_max);
    endtask

    task automatic wait_end(input int bound);
        int n;
        n = 0;
        while (!(bus.done === 1'b1 || bus.error === 1'b1) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!(bus.done === 1'b1 || bus.error === 1'b1)) begin
            checks++;
            errors++;
            $display("FAIL end_timeout: got done=%0b error=%0b expected one set within %0d cycles",
                     bus.done, bus.error, bound);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [79:0] stream;   // byte k at [8k+7:8k]
        logic [7:0]  nbytes;
        logic [7:0]  nwords;
        logic [63:0] words;    // word i at [32i+31:32i]
        logic        exp_done;
        logic        exp_error;
        logic [8:0]  exp_wc;
        logic [7:0]  gap_max;
        logic [7:0]  exp_lat;  // first byte edge to done/error, 0 = unchecked
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];
    vec_t v;
    int   lat;
    logic [8:0] wc_snap;

    initial begin
        // 02 00 13 05 50 00 93 05 A0 00 : two words, valid held high
        vecs[0] = '{stream: 80'h00A0_0593_0050_0513_0002, nbytes: 8'd10, nwords: 8'd2,
                    words: 64'h00A00593_00500513, exp_done: 1'b1, exp_error: 1'b0,
                    exp_wc: 9'd2, gap_max: 8'd0, exp_lat: 8'd12};
        // 00 00 : zero-length image
        vecs[1] = '{stream: 80'h0000, nbytes: 8'd2, nwords: 8'd0, words: 64'h0,
                    exp_done: 1'b1, exp_error: 1'b0, exp_wc: 9'd0, gap_max: 8'd0, exp_lat: 8'd2};
        // 01 01 : N=257 > DEPTH
        vecs[2] = '{stream: 80'h0101, nbytes: 8'd2, nwords: 8'd0, words: 64'h0,
                    exp_done: 1'b0, exp_error: 1'b1, exp_wc: 9'd0, gap_max: 8'd0, exp_lat: 8'd2};
        // 01 00 EF BE AD DE : recovery from ERR
        vecs[3] = '{stream: 80'hDEAD_BEEF_0001, nbytes: 8'd6, nwords: 8'd1,
                    words: 64'h00000000_DEADBEEF, exp_done: 1'b1, exp_error: 1'b0,
                    exp_wc: 9'd1, gap_max: 8'd0, exp_lat: 8'd7};
        // two-word image with random in_valid gaps
        vecs[4] = '{stream: 80'h00A0_0593_0050_0513_0002, nbytes: 8'd10, nwords: 8'd2,
                    words: 64'h00A00593_00500513, exp_done: 1'b1, exp_error: 1'b0,
                    exp_wc: 9'd2, gap_max: 8'd3, exp_lat: 8'd0};
        // 00 80 : N=0x8000, oversize through the high byte only
        vecs[5] = '{stream: 80'h8000, nbytes: 8'd2, nwords: 8'd0, words: 64'h0,
                    exp_done: 1'b0, exp_error: 1'b1, exp_wc: 9'd0, gap_max: 8'd0, exp_lat: 8'd2};
        // 01 00 78 56 34 12 with gaps, from ERR
        vecs[6] = '{stream: 80'h1234_5678_0001, nbytes: 8'd6, nwords: 8'd1,
                    words: 64'h00000000_12345678, exp_done: 1'b1, exp_error: 1'b0,
                    exp_wc: 9'd1, gap_max: 8'd2, exp_lat: 8'd0};

        // ---- reset, with a byte offered in IDLE ----
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        rst          = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_core_rst",  bus.core_rst,   1);
        check("rst_in_ready",  bus.in_ready,   0);
        check("rst_imem_we",   bus.imem_we,    0);
        check("rst_busy",      bus.busy,       0);
        check("rst_done",      bus.done,       0);
        check("rst_error",     bus.error,      0);
        check("rst_word_count", bus.word_count, 0);
        check("rst_addr",      bus.imem_addr,  0);
        check("rst_wdata",     bus.imem_wdata, 0);
        check("rst_state",     bus.state,      0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_state",    bus.state,      0);
        check("idle_in_ready", bus.in_ready,   0);
        bus.in_valid = 1'b0;

        // ---- table of complete loads ----
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            for (int w = 0; w < int'(v.nwords); w++)
                exp_q.push_back({ADDR_W'(w), v.words[32*w +: 32]});
            pulse_start();
            check("start_core_rst", bus.core_rst,   1);
            check("start_busy",     bus.busy,       1);
            check("start_done",     bus.done,       0);
            check("start_error",    bus.error,      0);
            check("start_wc",       bus.word_count, 0);
            first_pending = 1'b1;
            for (int k = 0; k < int'(v.nbytes); k++)
                send_byte(v.stream[8*k +: 8], int'(v.gap_max));
            // in_valid stays high: trailing bytes must be ignored.
            bus.in_data = 8'hFF;
            wait_end(40);
            lat = cycle - t_first + 1;
            if (v.exp_lat != 8'd0) check("latency", lat, v.exp_lat);
            check("end_done",     bus.done,       v.exp_done);
            check("end_error",    bus.error,      v.exp_error);
            check("end_core_rst", bus.core_rst,   !v.exp_done);
            check("end_wc",       bus.word_count, v.exp_wc);
            check("end_busy",     bus.busy,       0);
            check("end_in_ready", bus.in_ready,   0);
            wc_snap = bus.word_count;
            repeat (3) @(negedge clk);
            check("hold_wc",      bus.word_count, wc_snap);
            check("hold_done",    bus.done,       v.exp_done);
            check("writes_seen",  exp_q.size(),   0);
            bus.in_valid = 1'b0;
            @(negedge clk);
        end

        // ---- start pulsed while busy is ignored ----
        exp_q.push_back({8'd0, 32'h0BADF00D});
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h0D, 0);
        bus.start = 1'b1;
        send_byte(8'hF0, 0);
        bus.start = 1'b0;
        send_byte(8'hAD, 0);
        send_byte(8'h0B, 0);
        bus.in_valid = 1'b0;
        wait_end(40);
        check("busy_start_done", bus.done,       1);
        check("busy_start_wc",   bus.word_count, 1);
        check("busy_start_seen", exp_q.size(),   0);

        // ---- N == DEPTH, last write lands at DEPTH-1 ----
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] w;
            w = {8'(i), ~8'(i), 8'hA5, 8'(i * 3)};
            exp_q.push_back({8'(i), w});
            send_word(w, 0);
        end
        bus.in_valid = 1'b0;
        wait_end(40);
        check("full_done",     bus.done,       1);
        check("full_error",    bus.error,      0);
        check("full_core_rst", bus.core_rst,   0);
        check("full_wc",       bus.word_count, DEPTH);
        check("full_seen",     exp_q.size(),   0);

        // ---- reset after two data bytes, then a full reload ----
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_state",    bus.state,      0);
        check("midrst_core_rst", bus.core_rst,   1);
        check("midrst_busy",     bus.busy,       0);
        check("midrst_imem_we",  bus.imem_we,    0);
        check("midrst_wc",       bus.word_count, 0);
        check("midrst_done",     bus.done,       0);
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back({8'd0, 32'h00500513});
        exp_q.push_back({8'd1, 32'h00A00593});
        pulse_start();
        send_byte(8'h02, 1);
        send_byte(8'h00, 1);
        send_word(32'h00500513, 1);
        send_word(32'h00A00593, 1);
        bus.in_valid = 1'b0;
        wait_end(40);
        check("reload_done",     bus.done,       1);
        check("reload_core_rst", bus.core_rst,   0);
        check("reload_wc",       bus.word_count, 2);
        check("reload_seen",     exp_q.size(),   0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish before 500000 time units");
        $fatal(1, "timeout");
    end
endmodule
